// File: rtl/water_level_pkg.sv
// Shared types and default constants for the water pump controller slice.
package water_level_pkg;

  // Width of the level code coming from the level indicator
  localparam int LEVEL_W = 3;

  // Default tuning
  localparam int DEF_STABLE_CYCLES  = 4;
  localparam int DEF_LOW_THRESH     = 1;
  localparam int DEF_HIGH_THRESH    = 6;
  localparam int DEF_MIN_ON_CYCLES  = 8;
  localparam int DEF_MIN_OFF_CYCLES = 4;
  localparam int DEF_FILL_TIMEOUT   = 32;

  // Controller state; the encoding is visible on state_o
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_FILLING  = 2'b01,
    ST_COOLDOWN = 2'b10,
    ST_FAULT    = 2'b11
  } state_e;

endpackage

// File: rtl/level_debouncer.sv
// Debounces the raw level code: a value must be seen on STABLE_CYCLES
// consecutive edges before it is published on level_q.
module level_debouncer #(
  parameter int LEVEL_W       = 3,
  parameter int STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LEVEL_W-1:0] level_in,
  output logic [LEVEL_W-1:0] level_q,
  output logic               level_valid
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [LEVEL_W-1:0] cand;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  // Next run length: restart at 1 on a new value, otherwise saturating count
  always_comb begin
    cnt_nxt = cnt;
    if (level_in != cand)    cnt_nxt = CNT_W'(1);
    else if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
  end

  // Track candidate and publish it once its run reaches STABLE_CYCLES
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand        <= '0;
      cnt         <= '0;
      level_q     <= '0;
      level_valid <= 1'b0;
    end else begin
      cand <= level_in;
      cnt  <= cnt_nxt;
      // cand_next always equals level_in, so publish level_in directly
      if (cnt_nxt == CNT_MAX) begin
        level_q     <= level_in;
        level_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/water_pump_controller.sv
// Hysteresis pump controller: debounced level in, pump drive and dry-run
// alarm out, with minimum on/off times and a fill-progress timeout.
module water_pump_controller
  import water_level_pkg::*;
#(
  parameter int LEVEL_W        = water_level_pkg::LEVEL_W,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int LOW_THRESH     = DEF_LOW_THRESH,
  parameter int HIGH_THRESH    = DEF_HIGH_THRESH,
  parameter int MIN_ON_CYCLES  = DEF_MIN_ON_CYCLES,
  parameter int MIN_OFF_CYCLES = DEF_MIN_OFF_CYCLES,
  parameter int FILL_TIMEOUT   = DEF_FILL_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LEVEL_W-1:0] level_in,
  input  logic               enable,
  output logic               pump_on,
  output logic               alarm,
  output logic [LEVEL_W-1:0] level_q,
  output logic               level_valid,
  output logic [1:0]         state_o
);

  localparam logic [1:0] S_IDLE     = 2'(ST_IDLE);
  localparam logic [1:0] S_FILLING  = 2'(ST_FILLING);
  localparam logic [1:0] S_COOLDOWN = 2'(ST_COOLDOWN);
  localparam logic [1:0] S_FAULT    = 2'(ST_FAULT);

  localparam int ON_W   = $clog2(MIN_ON_CYCLES + 1);
  localparam int OFF_W  = $clog2(MIN_OFF_CYCLES + 1);
  localparam int PROG_W = $clog2(FILL_TIMEOUT + 1);

  localparam logic [ON_W-1:0]    ON_MAX    = ON_W'(MIN_ON_CYCLES);
  localparam logic [ON_W-1:0]    ON_LAST   = ON_W'(MIN_ON_CYCLES - 1);
  localparam logic [OFF_W-1:0]   OFF_MAX   = OFF_W'(MIN_OFF_CYCLES);
  localparam logic [OFF_W-1:0]   OFF_LAST  = OFF_W'(MIN_OFF_CYCLES - 1);
  localparam logic [PROG_W-1:0]  PROG_MAX  = PROG_W'(FILL_TIMEOUT);
  localparam logic [PROG_W-1:0]  PROG_LAST = PROG_W'(FILL_TIMEOUT - 1);
  localparam logic [LEVEL_W-1:0] LOW_L     = LEVEL_W'(LOW_THRESH);
  localparam logic [LEVEL_W-1:0] HIGH_L    = LEVEL_W'(HIGH_THRESH);

  logic [1:0]         state;
  logic [ON_W-1:0]    on_cnt;
  logic [OFF_W-1:0]   off_cnt;
  logic [PROG_W-1:0]  prog_cnt;
  logic [LEVEL_W-1:0] max_lvl;
  logic               rising;

  level_debouncer #(
    .LEVEL_W       (LEVEL_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_deb (
    .clk         (clk),
    .rst_n       (rst_n),
    .level_in    (level_in),
    .level_q     (level_q),
    .level_valid (level_valid)
  );

  // Fill progress means the debounced level beat the best seen this fill
  assign rising = (level_q > max_lvl);

  // Pump state machine with its on/off/progress timers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      on_cnt   <= '0;
      off_cnt  <= '0;
      prog_cnt <= '0;
      max_lvl  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable && level_valid && level_q <= LOW_L) begin
            state    <= S_FILLING;
            on_cnt   <= '0;
            prog_cnt <= '0;
            max_lvl  <= level_q;
          end
        end
        S_FILLING: begin
          if (on_cnt != ON_MAX) on_cnt <= on_cnt + 1'b1;
          if (rising) begin
            max_lvl  <= level_q;
            prog_cnt <= '0;
          end else if (prog_cnt != PROG_MAX) begin
            prog_cnt <= prog_cnt + 1'b1;
          end
          // Disable wins over everything, including the minimum on time
          if (!enable) begin
            state   <= S_COOLDOWN;
            off_cnt <= '0;
          end else if (!rising && prog_cnt == PROG_LAST) begin
            state <= S_FAULT;
          end else if (level_q >= HIGH_L && on_cnt >= ON_LAST) begin
            state   <= S_COOLDOWN;
            off_cnt <= '0;
          end
        end
        S_COOLDOWN: begin
          if (off_cnt != OFF_MAX) off_cnt <= off_cnt + 1'b1;
          if (off_cnt >= OFF_LAST) state <= S_IDLE;
        end
        default: begin
          // Latched until the operator drops enable
          if (!enable) state <= S_IDLE;
        end
      endcase
    end
  end

  assign pump_on = (state == S_FILLING);
  assign alarm   = (state == S_FAULT);
  assign state_o = state;

endmodule
